// File: rtl/data_axi_responder_pkg.sv
// Shared definitions for the data-side AXI-lite responder and its strobe encoder.
// Contents: FSM state encoding, AXI response codes, peripheral mask codes and
// the strobe-to-mask mapping used by wstrb_mask_enc.
package data_axi_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_COLLECT = 3'd1,
    ST_WR_ISSUE   = 3'd2,
    ST_WR_RESP    = 3'd3,
    ST_RD_WAIT    = 3'd4,
    ST_RD_RESP    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b10;
  localparam logic [1:0] MASK_NONE = 2'b11;

  function automatic logic [1:0] strb_to_mask(input logic [3:0] strb);
    case (strb)
      4'b0001: return MASK_BYTE;
      4'b0011: return MASK_HALF;
      4'b1111: return MASK_WORD;
      default: return MASK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wstrb_mask_enc.sv
// Combinational write-strobe to peripheral-mask encoder with alignment check.
// Ports:
//   i_wstrb   [3:0] AXI write strobe
//   i_addr_lo [1:0] low address bits of the access
//   o_mask    [1:0] peripheral mask (BYTE/HALF/WORD/NONE)
//   o_err           unsupported strobe or misaligned half/word access
module wstrb_mask_enc
  import data_axi_responder_pkg::*;
(
  input  logic [3:0] i_wstrb,
  input  logic [1:0] i_addr_lo,
  output logic [1:0] o_mask,
  output logic       o_err
);

  always_comb begin
    o_mask = strb_to_mask(i_wstrb);
    o_err  = (o_mask == MASK_NONE)
           | ((o_mask == MASK_HALF) & i_addr_lo[0])
           | ((o_mask == MASK_WORD) & (i_addr_lo != 2'b00));
  end

endmodule

// File: rtl/data_axi_responder.sv
// Data-side AXI-lite slave: converts one-outstanding AR/R and AW/W/B traffic to
// the single-port peripheral bus (addr / wen / mask / wdata / rdata).
// Optional build macro: DATA_AXI_ERR_EN enables alignment/strobe error checks
// and SLVERR responses; without it every access is performed and resp is OKAY.
// Parameters: RD_LATENCY (1..3) bus read latency, ADDR_W address width (<=32).
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_s_ar*/o_s_arready           read address channel
//   o_s_r*/i_s_rready             read data channel
//   i_s_aw*/o_s_awready           write address channel
//   i_s_w*/o_s_wready             write data channel
//   o_s_b*/i_s_bready             write response channel
//   o_perip_*/i_perip_rdata       peripheral bus
//
// state         | meaning
// ST_IDLE       | ready for AR, AW and W
// ST_WR_COLLECT | one of AW/W held, waiting for the other
// ST_WR_ISSUE   | single-cycle peripheral write
// ST_WR_RESP    | B response pending
// ST_RD_WAIT    | address on bus, counting read latency
// ST_RD_RESP    | R response pending
module data_axi_responder
  import data_axi_responder_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_s_araddr,
  input  logic              i_s_arvalid,
  output logic              o_s_arready,
  output logic [31:0]       o_s_rdata,
  output logic [1:0]        o_s_rresp,
  output logic              o_s_rvalid,
  input  logic              i_s_rready,
  input  logic [ADDR_W-1:0] i_s_awaddr,
  input  logic              i_s_awvalid,
  output logic              o_s_awready,
  input  logic [31:0]       i_s_wdata,
  input  logic [3:0]        i_s_wstrb,
  input  logic              i_s_wvalid,
  output logic              o_s_wready,
  output logic [1:0]        o_s_bresp,
  output logic              o_s_bvalid,
  input  logic              i_s_bready,
  output logic [31:0]       o_perip_addr,
  output logic              o_perip_wen,
  output logic [1:0]        o_perip_mask,
  output logic [31:0]       o_perip_wdata,
  input  logic [31:0]       i_perip_rdata
);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_aw_held, r_w_held;
  logic [1:0]        r_cnt;
  logic [31:0]       r_rdata;
  logic [31:0]       w_addr_ext;
  logic [1:0]        w_mask;
  logic              w_wr_err;
  logic              w_wr_block;
  logic              w_rd_blank;
  logic              w_aw_fire, w_w_fire, w_ar_fire;

  wstrb_mask_enc u_enc (
    .i_wstrb   (r_wstrb),
    .i_addr_lo (r_addr[1:0]),
    .o_mask    (w_mask),
    .o_err     (w_wr_err)
  );

`ifdef DATA_AXI_ERR_EN
  logic       r_rd_err;
  logic [1:0] r_rresp, r_bresp;
  assign w_wr_block = w_wr_err;
  // Reads are word accesses; a misaligned one never reaches the bus.
  assign w_rd_blank = (r_state == ST_RD_WAIT) & r_rd_err;
  assign o_s_rresp  = i_rst ? RESP_OKAY : r_rresp;
  assign o_s_bresp  = i_rst ? RESP_OKAY : r_bresp;
`else
  logic w_unused;
  assign w_unused   = w_wr_err;
  assign w_wr_block = 1'b0;
  assign w_rd_blank = 1'b0;
  assign o_s_rresp  = RESP_OKAY;
  assign o_s_bresp  = RESP_OKAY;
`endif

  assign w_aw_fire = i_s_awvalid & o_s_awready;
  assign w_w_fire  = i_s_wvalid  & o_s_wready;
  assign w_ar_fire = i_s_arvalid & o_s_arready;

  always_comb begin
    w_addr_ext               = '0;
    w_addr_ext[ADDR_W-1:0]   = r_addr;
  end

  assign o_perip_addr  = (i_rst | w_rd_blank) ? 32'd0 : w_addr_ext;
  assign o_perip_wdata = i_rst ? 32'd0 : r_wdata;
  assign o_s_rdata     = i_rst ? 32'd0 : r_rdata;

  always_comb begin
    w_state_nxt  = r_state;
    o_s_arready  = 1'b0;
    o_s_awready  = 1'b0;
    o_s_wready   = 1'b0;
    o_s_rvalid   = 1'b0;
    o_s_bvalid   = 1'b0;
    o_perip_wen  = 1'b0;
    o_perip_mask = MASK_NONE;
    if (!i_rst) begin
      case (r_state)
        ST_IDLE: begin
          o_s_awready = 1'b1;
          o_s_wready  = 1'b1;
          // Only valid-dependent ready: a pending store blocks a concurrent
          // load so stores are never reordered behind loads.
          o_s_arready = ~(i_s_awvalid | i_s_wvalid);
          if (i_s_awvalid & i_s_wvalid)      w_state_nxt = ST_WR_ISSUE;
          else if (i_s_awvalid | i_s_wvalid) w_state_nxt = ST_WR_COLLECT;
          else if (i_s_arvalid)              w_state_nxt = ST_RD_WAIT;
        end
        ST_WR_COLLECT: begin
          o_s_awready = ~r_aw_held;
          o_s_wready  = ~r_w_held;
          if ((i_s_awvalid & ~r_aw_held) | (i_s_wvalid & ~r_w_held))
            w_state_nxt = ST_WR_ISSUE;
        end
        ST_WR_ISSUE: begin
          o_perip_wen  = ~w_wr_block;
          o_perip_mask = w_wr_block ? MASK_NONE : w_mask;
          w_state_nxt  = ST_WR_RESP;
        end
        ST_WR_RESP: begin
          o_s_bvalid = 1'b1;
          if (i_s_bready) w_state_nxt = ST_IDLE;
        end
        ST_RD_WAIT: begin
          if (r_cnt == 2'd0) w_state_nxt = ST_RD_RESP;
        end
        ST_RD_RESP: begin
          o_s_rvalid = 1'b1;
          if (i_s_rready) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_cnt     <= '0;
      r_rdata   <= '0;
`ifdef DATA_AXI_ERR_EN
      r_rd_err  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_bresp   <= RESP_OKAY;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_aw_fire) begin
        r_addr    <= i_s_awaddr;
        r_aw_held <= 1'b1;
      end
      if (w_w_fire) begin
        r_wdata  <= i_s_wdata;
        r_wstrb  <= i_s_wstrb;
        r_w_held <= 1'b1;
      end
      if (w_ar_fire) begin
        r_addr <= i_s_araddr;
        r_cnt  <= 2'(RD_LATENCY - 1);
`ifdef DATA_AXI_ERR_EN
        r_rd_err <= (i_s_araddr[1:0] != 2'b00);
`endif
      end
      if (r_state == ST_WR_ISSUE) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
`ifdef DATA_AXI_ERR_EN
        r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
`endif
      end
      if (r_state == ST_RD_WAIT) begin
        if (r_cnt == 2'd0) begin
`ifdef DATA_AXI_ERR_EN
          r_rdata <= r_rd_err ? 32'd0 : i_perip_rdata;
          r_rresp <= r_rd_err ? RESP_SLVERR : RESP_OKAY;
`else
          r_rdata <= i_perip_rdata;
`endif
        end else begin
          r_cnt <= r_cnt - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_axi_responder.sv
module tb_data_axi_responder;

  localparam int LAT = 2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_s_araddr = '0;
  logic        i_s_arvalid = 1'b0;
  logic        o_s_arready;
  logic [31:0] o_s_rdata;
  logic [1:0]  o_s_rresp;
  logic        o_s_rvalid;
  logic        i_s_rready;
  logic [31:0] i_s_awaddr = '0;
  logic        i_s_awvalid = 1'b0;
  logic        o_s_awready;
  logic [31:0] i_s_wdata = '0;
  logic [3:0]  i_s_wstrb = '0;
  logic        i_s_wvalid = 1'b0;
  logic        o_s_wready;
  logic [1:0]  o_s_bresp;
  logic        o_s_bvalid;
  logic        i_s_bready;
  logic [31:0] o_perip_addr;
  logic        o_perip_wen;
  logic [1:0]  o_perip_mask;
  logic [31:0] o_perip_wdata;
  logic [31:0] i_perip_rdata;

  data_axi_responder #(.RD_LATENCY(LAT), .ADDR_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_s_araddr(i_s_araddr), .i_s_arvalid(i_s_arvalid), .o_s_arready(o_s_arready),
    .o_s_rdata(o_s_rdata), .o_s_rresp(o_s_rresp), .o_s_rvalid(o_s_rvalid), .i_s_rready(i_s_rready),
    .i_s_awaddr(i_s_awaddr), .i_s_awvalid(i_s_awvalid), .o_s_awready(o_s_awready),
    .i_s_wdata(i_s_wdata), .i_s_wstrb(i_s_wstrb), .i_s_wvalid(i_s_wvalid), .o_s_wready(o_s_wready),
    .o_s_bresp(o_s_bresp), .o_s_bvalid(o_s_bvalid), .i_s_bready(i_s_bready),
    .o_perip_addr(o_perip_addr), .o_perip_wen(o_perip_wen), .o_perip_mask(o_perip_mask),
    .o_perip_wdata(o_perip_wdata), .i_perip_rdata(i_perip_rdata)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Peripheral: data is a fixed function of the address, presented LAT-1
  // cycles after the address (one register stage for LAT=2).
  function automatic logic [31:0] bus_fn(input logic [31:0] a);
    return a ^ 32'h9234_5658;
  endfunction
  logic [31:0] bus_q = '0;
  always @(posedge i_clk) bus_q <= bus_fn(o_perip_addr);
  assign i_perip_rdata = bus_q;

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic void bad(input string nm);
    n_total++;
    $display("FAIL %s: event not expected (cycle %0d)", nm, cyc);
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  mask;
    int          t;
  } wr_t;
  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          t;
  } rsp_t;

  wr_t  q_wr[$];
  rsp_t q_b[$];
  rsp_t q_r[$];

  // Reference model
  function automatic logic [1:0] ref_mask(input logic [3:0] s);
    if (s == 4'b0001) return 2'b00;
    if (s == 4'b0011) return 2'b01;
    if (s == 4'b1111) return 2'b10;
    return 2'b11;
  endfunction

  function automatic void push_wr(input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] s, input int t);
    wr_t  w;
    rsp_t b;
    bit   err = 1'b0;
`ifdef DATA_AXI_ERR_EN
    if (s == 4'b0011)      err = a[0];
    else if (s == 4'b1111) err = (a % 4) != 0;
    else if (s != 4'b0001) err = 1'b1;
`endif
    if (!err) begin
      w.addr = a; w.data = d; w.mask = ref_mask(s); w.t = t + 1;
      q_wr.push_back(w);
    end
    b.data = '0; b.resp = err ? 2'b10 : 2'b00; b.t = t + 2;
    q_b.push_back(b);
  endfunction

  function automatic void push_rd(input logic [31:0] a, input int t);
    rsp_t r;
    r.data = bus_fn(a); r.resp = 2'b00; r.t = t + 1 + LAT;
`ifdef DATA_AXI_ERR_EN
    if ((a % 4) != 0) begin r.data = '0; r.resp = 2'b10; end
`endif
    q_r.push_back(r);
  endfunction

  // Backpressure
  bit stall_r = 1'b0;
  initial begin
    i_s_rready = 1'b0;
    i_s_bready = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      i_s_rready = stall_r ? 1'b0 : ($urandom_range(0, 3) != 0);
      i_s_bready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard
  bit r_new = 1'b1;
  bit b_new = 1'b1;
  always @(negedge i_clk) begin
    if (o_perip_wen) begin
      if (q_wr.size() == 0) bad("unexpected_wen");
      else begin
        wr_t e;
        e = q_wr.pop_front();
        chk("wen_addr", o_perip_addr, e.addr);
        chk("wen_wdata", o_perip_wdata, e.data);
        chk("wen_mask", 32'(o_perip_mask), 32'(e.mask));
        chk("wen_cycle", cyc, e.t);
      end
    end else begin
      chk("idle_mask", 32'(o_perip_mask), 32'h3);
    end
    if (o_s_bvalid) begin
      if (q_b.size() == 0) bad("unexpected_bvalid");
      else begin
        if (b_new) begin chk("bvalid_cycle", cyc, q_b[0].t); b_new = 1'b0; end
        chk("bresp", 32'(o_s_bresp), 32'(q_b[0].resp));
        if (i_s_bready) begin void'(q_b.pop_front()); b_new = 1'b1; end
      end
    end
    if (o_s_rvalid) begin
      if (q_r.size() == 0) bad("unexpected_rvalid");
      else begin
        if (r_new) begin chk("rvalid_cycle", cyc, q_r[0].t); r_new = 1'b0; end
        chk("rdata", o_s_rdata, q_r[0].data);
        chk("rresp", 32'(o_s_rresp), 32'(q_r[0].resp));
        if (i_s_rready) begin void'(q_r.pop_front()); r_new = 1'b1; end
      end
    end
  end

  // Stimulus
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int mode, input int gap);
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    int n = 0;
    @(posedge i_clk); #1;
    i_s_awaddr = a; i_s_wdata = d; i_s_wstrb = s;
    i_s_awvalid = (mode != 1);
    i_s_wvalid  = (mode != 2);
    while (!(aw_done && w_done)) begin
      @(negedge i_clk);
      if (aw_done && !w_done) chk("awready_held", 32'(o_s_awready), 32'h0);
      if (w_done && !aw_done) chk("wready_held", 32'(o_s_wready), 32'h0);
      if (i_s_awvalid && o_s_awready) aw_done = 1'b1;
      if (i_s_wvalid && o_s_wready) w_done = 1'b1;
      if (aw_done && w_done) push_wr(a, d, s, cyc);
      @(posedge i_clk); #1;
      if (aw_done) i_s_awvalid = 1'b0;
      if (w_done) i_s_wvalid = 1'b0;
      n++;
      if (n >= gap) begin
        if (!aw_done) i_s_awvalid = 1'b1;
        if (!w_done) i_s_wvalid = 1'b1;
      end
      if (n > 200 && !(aw_done && w_done)) begin
        bad("write_handshake_timeout");
        i_s_awvalid = 1'b0; i_s_wvalid = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_read(input logic [31:0] a, input bit expect_rsp);
    bit done = 1'b0;
    int n = 0;
    @(posedge i_clk); #1;
    i_s_araddr = a; i_s_arvalid = 1'b1;
    while (!done) begin
      @(negedge i_clk);
      if (o_s_arready) begin
        done = 1'b1;
        if (expect_rsp) push_rd(a, cyc);
      end
      @(posedge i_clk); #1;
      if (done) i_s_arvalid = 1'b0;
      n++;
      if (n > 200 && !done) begin
        bad("read_handshake_timeout");
        i_s_arvalid = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q_wr.size() + q_b.size() + q_r.size()) != 0 && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 300) begin
      bad("drain_timeout");
      q_wr.delete(); q_b.delete(); q_r.delete();
    end
    @(negedge i_clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rvalid"}, 32'(o_s_rvalid), 32'h0);
    chk({tag, "_bvalid"}, 32'(o_s_bvalid), 32'h0);
    chk({tag, "_wen"}, 32'(o_perip_wen), 32'h0);
    chk({tag, "_mask"}, 32'(o_perip_mask), 32'h3);
    chk({tag, "_paddr"}, o_perip_addr, 32'h0);
    chk({tag, "_pwdata"}, o_perip_wdata, 32'h0);
    chk({tag, "_rdata"}, o_s_rdata, 32'h0);
    chk({tag, "_rresp"}, 32'(o_s_rresp), 32'h0);
    chk({tag, "_bresp"}, 32'(o_s_bresp), 32'h0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_arready"}, 32'(o_s_arready), 32'h0);
    chk({tag, "_awready"}, 32'(o_s_awready), 32'h0);
    chk({tag, "_wready"}, 32'(o_s_wready), 32'h0);
    chk_quiet(tag);
  endtask

  task automatic pulse_reset(input string tag);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk_reset(tag);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk_quiet({tag, "_after"});
    chk({tag, "_after_awready"}, 32'(o_s_awready), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    int          n;

    // Reset: readies stay low even with requests pending.
    i_s_awvalid = 1'b1;
    i_s_arvalid = 1'b1;
    repeat (2) @(negedge i_clk);
    chk_reset("reset");
    @(posedge i_clk); #1;
    i_s_awvalid = 1'b0;
    i_s_arvalid = 1'b0;
    i_rst = 1'b0;

    // Word write, AW and W together.
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 0, 0);
    wait_drain();
    // W first, AW two cycles later.
    do_write(32'h8000_0003, 32'h0000_00AB, 4'b0001, 1, 2);
    wait_drain();
    // AW first, half word.
    do_write(32'h8000_0006, 32'h0000_5A5A, 4'b0011, 2, 1);
    wait_drain();

    // Read with response stalled for four cycles.
    @(negedge i_clk);
    stall_r = 1'b1;
    do_read(32'h8000_0020, 1'b1);
    n = 0;
    @(negedge i_clk);
    while (!o_s_rvalid && n < 20) begin @(negedge i_clk); n++; end
    chk("stall_rvalid_seen", 32'(o_s_rvalid), 32'h1);
    repeat (4) begin
      @(negedge i_clk);
      chk("stall_arready", 32'(o_s_arready), 32'h0);
      chk("stall_rvalid", 32'(o_s_rvalid), 32'h1);
    end
    stall_r = 1'b0;
    wait_drain();

    // Simultaneous AR and AW/W: write goes first.
    fork
      do_write(32'h8000_0040, 32'hCAFE_F00D, 4'b1111, 0, 0);
      do_read(32'h8000_0044, 1'b1);
      begin
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("sim_arready", 32'(o_s_arready), 32'h0);
        chk("sim_awready", 32'(o_s_awready), 32'h1);
      end
    join
    wait_drain();

    // Unsupported strobe and misaligned word read.
    do_write(32'h8000_0050, 32'h1122_3344, 4'b0110, 0, 0);
    wait_drain();
    do_read(32'h8000_0002, 1'b1);
    wait_drain();

    // Reset during RD_WAIT.
    do_read(32'h8000_0060, 1'b0);
    pulse_reset("rst_rdwait");
    repeat (6) @(negedge i_clk);

    // Reset during WR_COLLECT (AW held).
    @(posedge i_clk); #1;
    i_s_awaddr = 32'h8000_0070; i_s_awvalid = 1'b1;
    @(negedge i_clk);
    chk("collect_aw_accept", 32'(o_s_awready), 32'h1);
    @(posedge i_clk); #1;
    i_s_awvalid = 1'b0;
    pulse_reset("rst_collect");
    repeat (4) @(negedge i_clk);
    // Held AW must be gone: a fresh W-first write waits for its own AW.
    do_write(32'h8000_0074, 32'h7777_0001, 4'b1111, 1, 3);
    wait_drain();

    // Randomized traffic.
    repeat (80) begin
      a = 32'h8000_0000 | 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) begin
        do_read(a, 1'b1);
      end else begin
        case ($urandom_range(0, 4))
          0: s = 4'b0001;
          1: s = 4'b0011;
          2: s = 4'b1111;
          3: s = 4'b1111;
          default: s = 4'($urandom);
        endcase
        do_write(a, $urandom, s, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end
    end
    wait_drain();
    repeat (5) @(negedge i_clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
